// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice, one nibble per clock,
// least-significant nibble first, with the inter-nibble carry held in a flop.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   a, b   operands, captured on the accepting edge
//   cin    carry-in to nibble 0, captured on the accepting edge
//   busy   high while nibbles are being processed
//   done   one-cycle pulse, sum/ovf valid
//   sum    WIDTH+1 bit result, top bit is the final carry-out
//   ovf    two's-complement overflow of the final nibble
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH:0]   sum_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] slc_s;
    logic [4:0] slc_c;

    // 4-bit ripple slice; slc_c[0] is fed from the carry flop so
    // every nibble, including nibble 0, honours its carry-in.
    always_comb begin
        nib_a    = a_q[4*idx_q +: 4];
        nib_b    = b_q[4*idx_q +: 4];
        slc_c    = '0;
        slc_s    = '0;
        slc_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            slc_s[i]   = nib_a[i] ^ nib_b[i] ^ slc_c[i];
            slc_c[i+1] = (nib_a[i] & nib_b[i])
                       | (slc_c[i] & (nib_a[i] ^ nib_b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[4*idx_q +: 4] <= slc_s;
                    carry_q             <= slc_c[4];
                    if (idx_q == LAST) begin
                        // Overflow: carry into the MSB vs carry out of it.
                        sum_q[WIDTH] <= slc_c[4];
                        ovf_q        <= slc_c[3] ^ slc_c[4];
                        idx_q        <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
// Directed and random operations against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
    logic         ovf;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         since;
    logic [W:0] m_sum;
    logic       m_ovf;
    logic [W:0] q_sum[$];
    logic       q_ovf[$];

    function automatic logic [W:0] ref_sum(logic [W-1:0] x,
                                           logic [W-1:0] y,
                                           logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(logic [W-1:0] x,
                                     logic [W-1:0] y,
                                     logic c);
        logic [W:0] s;
        s = ref_sum(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: model decides acceptance at the edge, outputs checked
    // at the following falling edge.
    task automatic step();
        @(posedge clk);
        if (since > N) begin
            if (start) begin
                q_sum.push_back(ref_sum(a, b, cin));
                q_ovf.push_back(ref_ovf(a, b, cin));
                since = 0;
                m_sum = '0;
                m_ovf = 1'b0;
            end
        end else begin
            since++;
        end
        @(negedge clk);
        chk("busy", 32'(busy), 32'(since < N));
        chk("done", 32'(done), 32'(since == N));
        if (since == N) begin
            m_sum = q_sum.pop_front();
            m_ovf = q_ovf.pop_front();
        end
        if (since >= N) begin
            chk("sum", 32'(sum), 32'(m_sum));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    endtask

    task automatic op(logic [W-1:0] av, logic [W-1:0] bv, logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        repeat (N + 1) step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        since = N + 1;
        m_sum = '0;
        m_ovf = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        op(16'h1234, 16'h1111, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0);
        op(16'h8000, 16'h8000, 1'b0);
        op(16'h0000, 16'h0000, 1'b1);
        op(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) step();

        // Start held high with operands changing every cycle.
        start = 1'b1;
        repeat (3 * (N + 2)) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            step();
        end
        start = 1'b0;
        repeat (2) step();

        // Reset between E2 and E3 of an operation.
        a     = 16'hABCD;
        b     = 16'h1357;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        since = N + 1;
        m_sum = '0;
        m_ovf = 1'b0;
        q_sum.delete();
        q_ovf.delete();
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(busy | done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(16'h00FF, 16'h0001, 1'b0);
        chk("post_rst_sum", 32'(sum), 32'h00100);

        repeat (20) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencer that adds two WIDTH-bit operands over multiple cycles using one internal 4-bit adder slice, with the inter-nibble carry held in a flop. It sits between a requester with a start/done handshake and the shared 4-bit full-adder datapath. It trades throughput for area: one nibble per clock, least-significant nibble first.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; N = WIDTH/4 nibbles
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in to nibble 0, captured on the accepting edge
- busy  output  1  high while nibbles are being processed (RUN)
- done  output  1  one-cycle pulse; sum/ovf valid
- sum  output  WIDTH+1  result; bit WIDTH is the final carry-out
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- Datapath: 4-bit ripple slice of full-adder cells. Its carry-in is driven by the carry flop and must be honoured on every bit-0 cell.
- Registers: a_q, b_q (WIDTH), carry_q (1), idx (ceil(log2 N) bits, min 1), sum_q (WIDTH+1), ovf_q, state.
- States: IDLE, RUN, DONE.
- IDLE with start=1: capture a→a_q, b→b_q, cin→carry_q, idx←0, sum_q←0, ovf_q←0. Go to RUN.
- IDLE with start=0: hold.
- RUN, each edge:
  - sum_q[4*idx+3 : 4*idx] ← slice sum of a_q/b_q nibble idx plus carry_q.
  - carry_q ← slice carry-out.
  - idx ← idx+1.
- RUN at idx = N-1, additionally:
  - sum_q[WIDTH] ← slice carry-out.
  - ovf_q ← (carry into bit 3 of slice) XOR (slice carry-out).
  - Go to DONE.
- DONE: one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queueing and no abort.
- Operands on a/b/cin may change freely after the accepting edge. Only the captured copies are used.
- sum and ovf hold their last value from DONE through IDLE until the next accepted start clears them.
- Arithmetic: sum = a + b + cin, unsigned, WIDTH+1 bits, exact. ovf is meaningful for a signed interpretation only.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, ovf=0, idx=0, carry_q=0, a_q=b_q=0. Applies immediately, including mid-RUN or in DONE; any in-flight operation is discarded with no done pulse.
- Release: first edge with rst_n=1 may accept a start.
- Start accepted at edge E0. Then:
  - busy=1 after E0 through edge EN.
  - Nibble k is written at edge E(k+1).
  - After EN: busy=0, done=1, sum/ovf final.
  - After E(N+1): done=0, state IDLE.
- Latency: start edge to done asserted = N cycles (4 for WIDTH=16).
- Earliest next accepted start: edge E(N+2). Issue interval = N+2 cycles.
- busy and done are never high together. Both are registered, decoded from state, with no combinational path from start.
- WIDTH=4 (N=1): RUN lasts one cycle; done is asserted after E1.

## Test plan
- WIDTH=16, a=0x1234, b=0x1111, cin=0, start pulsed at E0 → busy high E0..E4, done single pulse after E4, sum=0x02345, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 → carry ripples through all 4 nibbles; sum=0x10000, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x08000, ovf=1. Then a=0x8000, b=0x8000 → sum=0x10000, ovf=1.
- a=0x0000, b=0x0000, cin=1 → sum=0x00001. Then a=0xFFFF, b=0xFFFF, cin=1 → sum=0x1FFFF, ovf=0.
- Start held high continuously, with a/b changed every cycle → accepts occur only at E0, E6, E12…; each result matches the operands sampled at its own accepting edge. Starts during RUN/DONE produce no effect.
- rst_n pulsed low between E2 and E3 of an operation → busy, done, sum, ovf all 0 immediately, no done pulse. After release, a fresh start with 0x00FF+0x0001 → sum=0x00100 after 4 cycles.
